// File: rtl/pwm_audio_capture_if.sv
// PWM audio capture bus.
//   pwm_in       : raw PWM line into the capture block (asynchronous to clk)
//   sample       : last recovered sample, held between updates
//   sample_valid : one-cycle pulse when sample updates
//   period_err   : one-cycle pulse on a malformed or stuck period
//   locked       : high after two consecutive good periods
// master = PWM source / result consumer, slave = capture block.
interface pwm_audio_capture_if #(
  parameter int unsigned DATA_W = 8
);
  logic              pwm_in;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              period_err;
  logic              locked;

  modport master (
    output pwm_in,
    input  sample,
    input  sample_valid,
    input  period_err,
    input  locked
  );

  modport slave (
    input  pwm_in,
    output sample,
    output sample_valid,
    output period_err,
    output locked
  );
endinterface

// File: rtl/pwm_audio_capture.sv
// Recovers 8-bit (DATA_W) samples from a PWM stream by measuring high time per
// 2**DATA_W-clock period. Flags malformed/stuck periods and reports lock.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : pwm_audio_capture_if.slave (pwm_in in; sample, sample_valid,
//             period_err, locked out; all outputs registered)
module pwm_audio_capture #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TOL         = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  pwm_audio_capture_if.slave    bus
);

  localparam int unsigned CNT_W  = DATA_W + 2;
  localparam int unsigned PERIOD = 1 << DATA_W;
  // Counter value at which the next increment would reach PERIOD+TOL+1.
  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] PER_LO = CNT_W'(PERIOD - TOL);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   r_s_d;
  logic                   r_rise, r_fall;
  state_e                 r_state, w_state_d;
  logic [CNT_W-1:0]       r_per, r_hi, w_per_d, w_hi_d;
  logic [DATA_W-1:0]      r_sample, w_sample_d;
  logic                   r_valid, w_valid_d;
  logic                   r_err, w_err_d;
  logic                   r_good, w_good_d;
  logic                   r_locked, w_locked_d;
  logic                   w_restart, w_ev_pass, w_ev_fail, w_ev_zero, w_ev_stuck;
  logic                   w_timeout, w_in_tol;
  logic [CNT_W-1:0]       w_per_inc, w_hi_inc;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Edge detect is registered so rise/fall line up with r_s_d, which is the
  // level the counters use.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pwm_in};
      r_s_d  <= w_s;
      r_rise <= w_s & ~r_s_d;
      r_fall <= ~w_s & r_s_d;
    end
  end

  assign w_per_inc = (r_per == '1) ? r_per : r_per + CNT_W'(1);
  assign w_hi_inc  = (r_hi == '1) ? r_hi : r_hi + CNT_W'(1);
  assign w_timeout = (r_per >= LIMIT);
  assign w_in_tol  = (r_per >= PER_LO) && (r_per <= LIMIT);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  // Next state and period events; a rise always beats a timeout.
  always_comb begin
    w_state_d  = r_state;
    w_restart  = 1'b0;
    w_ev_pass  = 1'b0;
    w_ev_fail  = 1'b0;
    w_ev_zero  = 1'b0;
    w_ev_stuck = 1'b0;
    case (r_state)
      StIdle: begin
        if (r_rise) begin
          w_restart = 1'b1;
          w_state_d = StHigh;
        end
      end
      StHigh: begin
        if (w_timeout) begin
          w_ev_stuck = 1'b1;
          w_state_d  = StIdle;
        end else if (r_fall) begin
          w_state_d = StLow;
        end
      end
      StLow: begin
        if (r_rise) begin
          w_restart = 1'b1;
          w_state_d = StHigh;
          if (w_in_tol) w_ev_pass = 1'b1;
          else          w_ev_fail = 1'b1;
        end else if (w_timeout) begin
          w_ev_zero = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Counter and output next values
  always_comb begin
    w_per_d    = r_per;
    w_hi_d     = r_hi;
    if (w_restart) begin
      w_per_d = CNT_W'(1);
      w_hi_d  = CNT_W'(1);
    end else if (w_ev_stuck || w_ev_zero || (r_state == StIdle)) begin
      w_per_d = '0;
      w_hi_d  = '0;
    end else begin
      w_per_d = w_per_inc;
      if ((r_state == StHigh) && r_s_d) w_hi_d = w_hi_inc;
    end

    w_valid_d  = w_ev_pass | w_ev_zero;
    w_err_d    = w_ev_fail | w_ev_stuck;
    w_sample_d = r_sample;
    if (w_ev_pass)      w_sample_d = r_hi[DATA_W-1:0];
    else if (w_ev_zero) w_sample_d = '0;

    w_good_d   = r_good;
    w_locked_d = r_locked;
    if (w_err_d) begin
      w_good_d   = 1'b0;
      w_locked_d = 1'b0;
    end else if (w_valid_d) begin
      w_good_d = 1'b1;
      if (r_good) w_locked_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_per    <= '0;
      r_hi     <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_good   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_per    <= w_per_d;
      r_hi     <= w_hi_d;
      r_sample <= w_sample_d;
      r_valid  <= w_valid_d;
      r_err    <= w_err_d;
      r_good   <= w_good_d;
      r_locked <= w_locked_d;
    end
  end

  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_valid;
  assign bus.period_err   = r_err;
  assign bus.locked       = r_locked;

endmodule

// File: tb/tb_pwm_audio_capture.sv
// Self-checking bench: two captures (TOL=0 and TOL=4) share one PWM line built
// from directed and random periods; a waveform-level reference model predicts
// every output each cycle.
module tb_pwm_audio_capture;

  localparam int unsigned DATA_W = 8;
  localparam int PER  = 256;
  localparam int LAT  = 4;      // SYNC_STAGES + 2
  localparam int MAXC = 16384;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pwm   = 1'b0;

  always #5 clk = ~clk;

  pwm_audio_capture_if #(.DATA_W(DATA_W)) u_if0 ();
  pwm_audio_capture_if #(.DATA_W(DATA_W)) u_if1 ();
  assign u_if0.pwm_in = pwm;
  assign u_if1.pwm_in = pwm;

  pwm_audio_capture #(.DATA_W(DATA_W), .TOL(0), .SYNC_STAGES(2)) u_dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if0)
  );

  pwm_audio_capture #(.DATA_W(DATA_W), .TOL(4), .SYNC_STAGES(2)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if1)
  );

  bit w [MAXC];
  int len;
  int cyc;
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: phase 0=idle 1=high 2=low, base = cycle per-count 0
  int         m_mode   [2];
  int         m_base   [2];
  bit         m_prev   [2];
  logic [7:0] m_sample [2];
  logic       m_valid  [2];
  logic       m_err    [2];
  logic       m_locked [2];
  int         m_good   [2];
  int         tol_of   [2];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s cycle %0d: got %04h expected %04h", tag, cyc, got, exp);
    end
  endtask

  task automatic add_level(input bit v, input int n);
    for (int i = 0; i < n; i++) if (len < MAXC) begin w[len] = v; len++; end
  endtask

  task automatic add_period(input int d, input int plen);
    for (int i = 0; i < plen; i++) if (len < MAXC) begin w[len] = (i < d); len++; end
  endtask

  function automatic int ones(input int a, input int b);
    int s = 0;
    for (int i = a; i < b; i++) s += int'(w[i]);
    return s;
  endfunction

  task automatic model_reset(input int k);
    m_mode[k] = 0; m_base[k] = 0; m_prev[k] = 1'b0;
    m_sample[k] = 8'h00; m_valid[k] = 1'b0; m_err[k] = 1'b0;
    m_locked[k] = 1'b0; m_good[k] = 0;
  endtask

  // Applies the capture rules to synchronised input cycle n.
  task automatic model_step(input int k, input int n);
    bit lv, rise, fall;
    int per, dev;
    lv   = w[n];
    rise = lv & ~m_prev[k];
    fall = ~lv & m_prev[k];
    m_prev[k]  = lv;
    m_valid[k] = 1'b0;
    m_err[k]   = 1'b0;
    per = n - m_base[k];
    if (m_mode[k] == 0) begin
      if (rise) begin m_base[k] = n; m_mode[k] = 1; end
    end else if (m_mode[k] == 1) begin
      if (per >= PER + tol_of[k]) begin m_err[k] = 1'b1; m_mode[k] = 0; end
      else if (fall) m_mode[k] = 2;
    end else begin
      if (rise) begin
        dev = (per > PER) ? per - PER : PER - per;
        if (dev <= tol_of[k]) begin
          m_valid[k]  = 1'b1;
          m_sample[k] = 8'(ones(m_base[k], n) % PER);
        end else begin
          m_err[k] = 1'b1;
        end
        m_base[k] = n;
        m_mode[k] = 1;
      end else if (per >= PER + tol_of[k]) begin
        m_valid[k]  = 1'b1;
        m_sample[k] = 8'h00;
        m_base[k]   = n + 1;
      end
    end
    if (m_err[k]) begin
      m_good[k] = 0; m_locked[k] = 1'b0;
    end else if (m_valid[k]) begin
      m_good[k]++;
      if (m_good[k] >= 2) m_locked[k] = 1'b1;
    end
  endtask

  function automatic logic [15:0] exp_of(input int k);
    return {5'b0, m_sample[k], m_valid[k], m_err[k], m_locked[k]};
  endfunction

  initial begin
    int rst_at, model_start, d, r, plen;
    tol_of[0] = 0;
    tol_of[1] = 4;
    model_reset(0);
    model_reset(1);
    model_start = 2 * MAXC;

    len = 0;
    add_level(1'b0, 8);
    repeat (4) add_period(8'h80, 256);
    repeat (2) add_period(8'h01, 256);
    repeat (2) add_period(8'hFF, 256);
    add_level(1'b0, 257 * 3 + 40);
    repeat (3) add_period(8'h40, 256);
    add_period(8'h40, 260);
    repeat (3) add_period(8'h40, 256);
    add_level(1'b1, 300);
    add_level(1'b0, 100);
    repeat (4) add_period(8'h80, 256);
    rst_at = len + 10;
    repeat (3) add_period(8'h80, 256);
    for (int i = 0; i < 20; i++) begin
      d = int'($urandom_range(255, 0));
      r = int'($urandom_range(7, 0));
      plen = (r == 0) ? 256 + int'($urandom_range(6, 1)) :
             (r == 1) ? 256 - int'($urandom_range(6, 1)) : 256;
      if (d >= plen) d = plen - 1;
      add_period(d, plen);
    end
    add_level(1'b0, 10);

    for (int m = 0; m < len + LAT; m++) begin
      @(negedge clk);
      cyc = m;
      if (rst_n && (m - LAT >= model_start)) begin
        model_step(0, m - LAT);
        model_step(1, m - LAT);
      end
      check_eq("dut_tol0", {5'b0, u_if0.sample, u_if0.sample_valid, u_if0.period_err,
                            u_if0.locked}, exp_of(0));
      check_eq("dut_tol4", {5'b0, u_if1.sample, u_if1.sample_valid, u_if1.period_err,
                            u_if1.locked}, exp_of(1));
      pwm = (m < len) ? w[m] : 1'b0;
      if (m == 5) begin
        #3 rst_n = 1'b1;
        model_start = m;
      end
      if (m == rst_at) begin
        #2 rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check_eq("rst_async0", {5'b0, u_if0.sample, u_if0.sample_valid, u_if0.period_err,
                                u_if0.locked}, 16'h0000);
        check_eq("rst_async1", {5'b0, u_if1.sample, u_if1.sample_valid, u_if1.period_err,
                                u_if1.locked}, 16'h0000);
      end
      if (m == rst_at + 3) begin
        #3 rst_n = 1'b1;
        model_start = m;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
